pwm_deadband_gen: RTL and testbench

//  Downstream stage of the n-bit PWM generator. Converts its single pwm_out into a complementary

---
 rtl/pwm_deadband_gen.sv | 137 +++++++++++++
 tb/tb_pwm_deadband_gen.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_deadband_gen.sv
// pwm_deadband_gen
//   Turns a single PWM waveform into a complementary high-side/low-side pair
//   for a half-bridge. A programmable dead time is inserted on each edge, so
//   the two sides are never active together. A dead-time interval that is
//   cut short by the opposite pwm_in level is reported on short_pulse_evt.
//
// Ports
//   sys_clk          system clock, all logic on posedge
//   sys_rst          asynchronous, active-high reset
//   sys_clk_en       0 = hold all state
//   en               0 = force IDLE (synchronous)
//   pwm_in           PWM waveform from the generator
//   rise_dly         dead-time cycles before pwm_h asserts
//   fall_dly         dead-time cycles before pwm_l asserts
//   pol_h / pol_l    1 = matching output is active-low
//   pwm_h / pwm_l    high-side / low-side drive (Moore decode ^ polarity)
//   db_active        1 while a dead-time interval is running
//   short_pulse_evt  one-cycle flag: a dead-time interval was aborted
module pwm_deadband_gen #(
  parameter int DB_W = 8
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            sys_clk_en,
  input  logic            en,
  input  logic            pwm_in,
  input  logic [DB_W-1:0] rise_dly,
  input  logic [DB_W-1:0] fall_dly,
  input  logic            pol_h,
  input  logic            pol_l,
  output logic            pwm_h,
  output logic            pwm_l,
  output logic            db_active,
  output logic            short_pulse_evt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DLY_H = 3'd1,
    H_ON  = 3'd2,
    DLY_L = 3'd3,
    L_ON  = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [DB_W-1:0] cnt, cnt_nxt;
  logic            evt_nxt;

  // Entry target for each side: a zero dead time skips the DLY state. The
  // counter is loaded with the delay either way; it is ignored in ON states.
  state_t h_entry, l_entry;
  assign h_entry = (rise_dly == '0) ? H_ON : DLY_H;
  assign l_entry = (fall_dly == '0) ? L_ON : DLY_L;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state           <= IDLE;
      cnt             <= '0;
      short_pulse_evt <= 1'b0;
    end else if (sys_clk_en) begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      short_pulse_evt <= evt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    evt_nxt   = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pwm_in) begin
            state_nxt = h_entry;
            cnt_nxt   = rise_dly;
          end else begin
            state_nxt = l_entry;
            cnt_nxt   = fall_dly;
          end
        end
        L_ON: begin
          if (pwm_in) begin
            state_nxt = h_entry;
            cnt_nxt   = rise_dly;
          end
        end
        H_ON: begin
          if (!pwm_in) begin
            state_nxt = l_entry;
            cnt_nxt   = fall_dly;
          end
        end
        DLY_H: begin
          if (!pwm_in) begin
            // pulse swallowed: turn straight around towards the low side
            state_nxt = l_entry;
            cnt_nxt   = fall_dly;
            evt_nxt   = 1'b1;
          end else if (cnt <= DB_W'(1)) begin
            // <= guards against a zero count, so cnt never wraps
            state_nxt = H_ON;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt   = cnt - DB_W'(1);
          end
        end
        DLY_L: begin
          if (pwm_in) begin
            state_nxt = h_entry;
            cnt_nxt   = rise_dly;
            evt_nxt   = 1'b1;
          end else if (cnt <= DB_W'(1)) begin
            state_nxt = L_ON;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt   = cnt - DB_W'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Moore outputs: only one state can drive each side, so the pair can never
  // be active together regardless of pwm_in.
  assign pwm_h     = (state == H_ON) ^ pol_h;
  assign pwm_l     = (state == L_ON) ^ pol_l;
  assign db_active = (state == DLY_H) || (state == DLY_L);

endmodule

// File: tb/tb_pwm_deadband_gen.sv
module tb_pwm_deadband_gen;
  localparam int DB_W = 8;

  logic            sys_clk = 1'b0;
  logic            sys_rst = 1'b0;
  logic            sys_clk_en = 1'b1;
  logic            en = 1'b0;
  logic            pwm_in = 1'b0;
  logic [DB_W-1:0] rise_dly = '0;
  logic [DB_W-1:0] fall_dly = '0;
  logic            pol_h = 1'b0;
  logic            pol_l = 1'b0;
  logic            pwm_h, pwm_l, db_active, short_pulse_evt;

  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] sb[$];   // expected {pwm_h, pwm_l, db_active, short_pulse_evt}
  logic [3:0] exp_v, got;

  pwm_deadband_gen #(.DB_W(DB_W)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .sys_clk_en(sys_clk_en), .en(en),
    .pwm_in(pwm_in), .rise_dly(rise_dly), .fall_dly(fall_dly),
    .pol_h(pol_h), .pol_l(pol_l), .pwm_h(pwm_h), .pwm_l(pwm_l),
    .db_active(db_active), .short_pulse_evt(short_pulse_evt)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // expected output word from active-high side levels and current polarity
  function automatic logic [3:0] mk(input logic h, input logic l, input logic db, input logic evt);
    return {h ^ pol_h, l ^ pol_l, db, evt};
  endfunction

  task automatic test_reset();
    pol_h = 1'b0; pol_l = 1'b1;
    #1 sys_rst = 1'b1;
    #1;
    got = {pwm_h, pwm_l, db_active, short_pulse_evt};
    n_vec++;
    if (got !== 4'b0100) begin
      n_err++; $display("FAIL reset_immediate got=%b want=%b", got, 4'b0100);
    end
    en = 1'b1; pwm_in = 1'b1;
    repeat (3) tick();
    got = {pwm_h, pwm_l, db_active, short_pulse_evt};
    n_vec++;
    if (got !== 4'b0100) begin
      n_err++; $display("FAIL reset_held got=%b want=%b", got, 4'b0100);
    end
  endtask

  // IDLE -> low side (fall_dly=5), then a rise with rise_dly=3
  task automatic test_rise();
    pol_l = 1'b0; en = 1'b1; rise_dly = 8'd3; fall_dly = 8'd5; pwm_in = 1'b0;
    sys_rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      sb.push_back(mk(1'b0, k >= 6, k <= 5, 1'b0));
      tick();
      exp_v = sb.pop_front(); got = {pwm_h, pwm_l, db_active, short_pulse_evt};
      n_vec++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL rise_low k=%0d got=%b want=%b", k, got, exp_v);
      end
    end
    pwm_in = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      sb.push_back(mk(k >= 4, 1'b0, k <= 3, 1'b0));
      tick();
      exp_v = sb.pop_front(); got = {pwm_h, pwm_l, db_active, short_pulse_evt};
      n_vec++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL rise_high k=%0d got=%b want=%b", k, got, exp_v);
      end
    end
  endtask

  // H_ON -> fall with fall_dly=5; db_active must last exactly 5 cycles
  task automatic test_fall();
    int db_cnt = 0;
    fall_dly = 8'd5; pwm_in = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      sb.push_back(mk(1'b0, k >= 6, k <= 5, 1'b0));
      tick();
      if (db_active) db_cnt++;
      exp_v = sb.pop_front(); got = {pwm_h, pwm_l, db_active, short_pulse_evt};
      n_vec++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL fall k=%0d got=%b want=%b", k, got, exp_v);
      end
    end
    n_vec++;
    if (db_cnt !== 5) begin
      n_err++; $display("FAIL fall_db_len got=%0d want=5", db_cnt);
    end
  endtask

  // 2-cycle high pulse with rise_dly=4 is swallowed; fall_dly changed
  // mid-interval must not affect the running count
  task automatic test_short_pulse();
    rise_dly = 8'd4; fall_dly = 8'd5;
    for (int k = 1; k <= 12; k++) begin
      pwm_in = (k <= 2);
      fall_dly = (k >= 4) ? 8'd1 : 8'd5;
      if (k <= 2)      sb.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
      else if (k == 3) sb.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1));
      else if (k <= 7) sb.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
      else             sb.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
      tick();
      exp_v = sb.pop_front(); got = {pwm_h, pwm_l, db_active, short_pulse_evt};
      n_vec++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL short_pulse k=%0d got=%b want=%b", k, got, exp_v);
      end
    end
    fall_dly = 8'd5;
  endtask

  // zero dead time, toggling every cycle, high side active-low
  task automatic test_zero_dly();
    rise_dly = 8'd0; fall_dly = 8'd0; pol_h = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      pwm_in = (k % 2 == 1);
      sb.push_back(mk(pwm_in, !pwm_in, 1'b0, 1'b0));
      tick();
      exp_v = sb.pop_front(); got = {pwm_h, pwm_l, db_active, short_pulse_evt};
      n_vec++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL zero_dly k=%0d got=%b want=%b", k, got, exp_v);
      end
      n_vec++;
      if (((pwm_h ^ pol_h) & (pwm_l ^ pol_l)) !== 1'b0) begin
        n_err++; $display("FAIL zero_dly_overlap k=%0d got h=%b l=%b want not both active", k, pwm_h, pwm_l);
      end
    end
    pol_h = 1'b0;
  endtask

  // freeze for 10 cycles mid-DLY_H with disturbing inputs, then resume
  task automatic test_clk_en();
    rise_dly = 8'd6; fall_dly = 8'd5; pwm_in = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      sb.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
      tick();
      exp_v = sb.pop_front(); got = {pwm_h, pwm_l, db_active, short_pulse_evt};
      n_vec++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL clk_en_pre k=%0d got=%b want=%b", k, got, exp_v);
      end
    end
    sys_clk_en = 1'b0; pwm_in = 1'b0; rise_dly = 8'd2;
    for (int k = 1; k <= 10; k++) begin
      sb.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
      tick();
      exp_v = sb.pop_front(); got = {pwm_h, pwm_l, db_active, short_pulse_evt};
      n_vec++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL clk_en_frozen k=%0d got=%b want=%b", k, got, exp_v);
      end
    end
    sys_clk_en = 1'b1; pwm_in = 1'b1; rise_dly = 8'd6;
    for (int k = 1; k <= 6; k++) begin
      sb.push_back(mk(k >= 5, 1'b0, k <= 4, 1'b0));
      tick();
      exp_v = sb.pop_front(); got = {pwm_h, pwm_l, db_active, short_pulse_evt};
      n_vec++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL clk_en_resume k=%0d got=%b want=%b", k, got, exp_v);
      end
    end
  endtask

  // two aborts in a row; event flag held through a clock-enable freeze
  task automatic test_back_to_back();
    rise_dly = 8'd6; fall_dly = 8'd5;
    for (int k = 1; k <= 13; k++) begin
      sys_clk_en = !(k >= 3 && k <= 5);
      if (k == 1)      pwm_in = 1'b0;
      else if (k == 2) pwm_in = 1'b1;
      else             pwm_in = 1'b0;
      if (k == 1)       sb.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
      else if (k <= 6)  sb.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1));
      else if (k <= 10) sb.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
      else              sb.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
      tick();
      exp_v = sb.pop_front(); got = {pwm_h, pwm_l, db_active, short_pulse_evt};
      n_vec++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL back_to_back k=%0d got=%b want=%b", k, got, exp_v);
      end
    end
    sys_clk_en = 1'b1;
  endtask

  // en=0 from H_ON, then async reset in the middle of DLY_L
  task automatic test_en_rst();
    pol_h = 1'b1; rise_dly = 8'd0; fall_dly = 8'd5;
    for (int k = 1; k <= 6; k++) begin
      en     = !(k >= 2 && k <= 4);
      pwm_in = (k <= 4);
      if (k == 1)      sb.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0));
      else if (k <= 4) sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
      else             sb.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
      tick();
      exp_v = sb.pop_front(); got = {pwm_h, pwm_l, db_active, short_pulse_evt};
      n_vec++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL en_off k=%0d got=%b want=%b", k, got, exp_v);
      end
    end
    pwm_in = 1'b1; rise_dly = 8'd3;
    #2 sys_rst = 1'b1;
    #1;
    exp_v = mk(1'b0, 1'b0, 1'b0, 1'b0); got = {pwm_h, pwm_l, db_active, short_pulse_evt};
    n_vec++;
    if (got !== exp_v) begin
      n_err++; $display("FAIL rst_async got=%b want=%b", got, exp_v);
    end
    tick();
    got = {pwm_h, pwm_l, db_active, short_pulse_evt};
    n_vec++;
    if (got !== exp_v) begin
      n_err++; $display("FAIL rst_held got=%b want=%b", got, exp_v);
    end
    sys_rst = 1'b0;
    sb.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
    tick();
    exp_v = sb.pop_front(); got = {pwm_h, pwm_l, db_active, short_pulse_evt};
    n_vec++;
    if (got !== exp_v) begin
      n_err++; $display("FAIL rst_release got=%b want=%b", got, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_fall();
    test_short_pulse();
    test_zero_dly();
    test_clk_en();
    test_back_to_back();
    test_en_rst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
